fv_qed_issue_sched: RTL
=======================

Name: fv_qed_issue_sched

Overview:
- Sequences instruction injection into the DUT fetch path for QED-style self-consistency checking.
- Alternates an ORIGINAL phase and a DUPLICATE phase with an equal accepted-instruction count, then drains the pipeline by counting commits.
- Pulses qed_ready when register-file equivalence may be checked.
- Sits between the solver-driven instruction source and the IF stall/valid controls of the FV harness.

Parameters:
- NCOMMIT, 1, commit lanes per cycle (matches FV_MAX_COMMIT_PER_CYCLE).
- CNT_W, 6, width of the issue counters.
- MAX_ORIG, 16, originals issued before a forced switch to DUP; range 1..2^CNT_W-1.
- TIMEOUT, 64, drain cycle limit (optional feature only).

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous reset, active-high (1 = reset).
- start  in  1  leave IDLE.
- instr_valid_in  in  1  source offers an instruction this cycle.
- instr_grant  in  1  DUT fetch accepts this cycle (IF_instruction_req_grant).
- switch_req  in  1  solver-free request to end the ORIG phase early.
- kill  in  1  DUT pipeline flush; aborts the current sequence.
- commit  in  NCOMMIT  per-lane commit strobes.
- issue_valid  out  1  instruction forwarded to the DUT.
- issue_is_dup  out  1  forwarded instruction is a duplicate (register remap select).
- fetch_stall  out  1  stall DUT fetch.
- qed_ready  out  1  one-cycle check strobe.
- orig_count  out  CNT_W  originals accepted in the current sequence.
- commit_count  out  CNT_W+1  commits seen in the current sequence.
- overcommit_err  out  1  sticky error flag.

Behaviour:
- Reset values: state=IDLE, counters 0, issue_valid=0, issue_is_dup=0, fetch_stall=1, qed_ready=0, overcommit_err=0.
- Reset mid-sequence returns immediately to these values.
- States are IDLE, ORIG, DUP, DRAIN, CHECK.
- accept = issue_valid & instr_grant.
- issue_valid = instr_valid_in & (state is ORIG or DUP); combinational, zero latency.
- fetch_stall = 1 in IDLE, DRAIN and CHECK; 0 in ORIG and DUP.
- IDLE -> ORIG when start=1.
- ORIG:
  - orig_count increments on accept.
  - -> DUP when orig_count >= 1 (post-increment value) and either switch_req=1 or orig_count reaches MAX_ORIG.
  - switch_req with orig_count=0 is ignored.
  - On the cycle orig_count reaches MAX_ORIG, the accept is counted and the state changes the next cycle. No further ORIG issue occurs.
- DUP:
  - issue_is_dup=1.
  - dup_count (internal) increments on accept.
  - -> DRAIN on the cycle dup_count reaches orig_count.
  - switch_req is ignored.
- DRAIN:
  - commit_count += popcount(commit) each cycle. Commits are also counted in ORIG and DUP.
  - -> CHECK when commit_count equals 2*orig_count. This equality uses the updated value; CNT_W+1 bits cannot overflow.
- CHECK: qed_ready=1 for exactly one cycle, then all counters clear and state -> ORIG.
- Overcommit: if an update would exceed 2*orig_count in DRAIN, set overcommit_err (sticky until reset).
  - commit_count saturates at 2*orig_count.
  - The state advances to CHECK as normal.
- Kill:
  - kill=1 in ORIG, DUP or DRAIN clears all counters and goes to ORIG next cycle. issue_valid is forced 0 that cycle.
  - Kill has priority over every other transition.
  - Kill in IDLE or CHECK is ignored.
- Simultaneous accept and commit in the same cycle: both counters update.

Optional Feature:
- Macro FV_QED_SCHED_TIMEOUT_EN.
- Defined:
  - An internal drain_timer counts cycles in DRAIN.
  - If the timer reaches TIMEOUT with no CHECK, timeout_err (extra 1-bit output, sticky, reset 0) is set.
  - The state then returns to ORIG with counters cleared; qed_ready is not pulsed.
  - The timer clears on DRAIN exit.
- Undefined: no timer and no timeout_err port; DRAIN waits indefinitely.

Test Plan:
- Reset asserted mid-DUP with orig_count=5 -> all outputs return to reset values in the same cycle; after release, state=IDLE and fetch_stall=1.
- start, 3 accepted originals, then switch_req -> exactly 3 accepts with issue_is_dup=1, fetch_stall rises. Then 6 single commits -> qed_ready high one cycle; orig_count=0 the next cycle.
- MAX_ORIG=16, switch_req never asserted -> state switches to DUP after the 16th accept; issue_valid=0 for the 17th offer while in ORIG.
- instr_valid_in=1 with instr_grant=0 for 4 cycles in DUP -> no counter change; DRAIN entry waits for grants.
- NCOMMIT=2, orig_count=2, commit=2'b11 then 2'b11 then 2'b01 -> CHECK after the second cycle. The extra commit after CHECK, in the new ORIG phase, counts toward the new sequence; no error.
- In DRAIN with 2*orig_count-1 commits already seen, commit=2'b11 -> overcommit_err=1, commit_count saturates, qed_ready still pulses.
- kill in DRAIN -> counters 0, state ORIG next cycle.
- With FV_QED_SCHED_TIMEOUT_EN, TIMEOUT=64 and no commits -> timeout_err set at drain cycle 64, state ORIG.

Source files
------------

// File: rtl/fv_qed_issue_sched.sv
// QED issue scheduler: ORIG / DUP instruction injection, commit-counted drain, qed_ready strobe.
// Optional drain watchdog with timeout_err output is enabled by defining FV_QED_SCHED_TIMEOUT_EN.
module fv_qed_issue_sched #(
  parameter int unsigned NCOMMIT  = 1,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned MAX_ORIG = 16
`ifdef FV_QED_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 64
`endif
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               start,
  input  logic               instr_valid_in,
  input  logic               instr_grant,
  input  logic               switch_req,
  input  logic               kill,
  input  logic [NCOMMIT-1:0] commit,
  output logic               issue_valid,
  output logic               issue_is_dup,
  output logic               fetch_stall,
  output logic               qed_ready,
  output logic [CNT_W-1:0]   orig_count,
  output logic [CNT_W:0]     commit_count,
  output logic               overcommit_err
`ifdef FV_QED_SCHED_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StOrig  = 3'd1;
  localparam logic [2:0] StDup   = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;

  localparam int unsigned PcW = $clog2(NCOMMIT + 1);

  logic [2:0]       r_state,      w_state_d;
  logic [CNT_W-1:0] r_orig_count, w_orig_count_d;
  logic [CNT_W-1:0] r_dup_count,  w_dup_count_d;
  logic [CNT_W:0]   r_commit_cnt, w_commit_cnt_d;
  logic             r_overcommit, w_overcommit_d;

  logic             w_issuing;
  logic             w_accept;
  logic             w_clear;
  logic [PcW-1:0]   w_popcnt;
  logic [CNT_W-1:0] w_orig_next;
  logic [CNT_W-1:0] w_dup_next;
  logic [CNT_W:0]   w_target;
  logic [CNT_W+1:0] w_commit_sum;

`ifdef FV_QED_SCHED_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  logic [TmrW-1:0] r_drain_timer, w_drain_timer_d;
  logic            r_timeout,     w_timeout_d;
  logic [TmrW-1:0] w_timer_next;
  assign w_timer_next = r_drain_timer + 1'b1;
`endif

  assign w_issuing   = (r_state == StOrig) || (r_state == StDup);
  // A flush squashes the instruction offered in the same cycle.
  assign issue_valid = instr_valid_in & w_issuing & ~kill;
  assign w_accept    = issue_valid & instr_grant;

  assign w_orig_next = r_orig_count + CNT_W'(w_accept);
  assign w_dup_next  = r_dup_count + CNT_W'(w_accept);
  assign w_target    = {r_orig_count, 1'b0};

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      w_popcnt = w_popcnt + PcW'(commit[i]);
    end
  end

  // One extra bit so an overshoot beyond the target is never hidden by wrap-around.
  assign w_commit_sum = {1'b0, r_commit_cnt} + (CNT_W+2)'(w_popcnt);

  always_comb begin
    w_state_d      = r_state;
    w_orig_count_d = r_orig_count;
    w_dup_count_d  = r_dup_count;
    w_commit_cnt_d = r_commit_cnt;
    w_overcommit_d = r_overcommit;
    w_clear        = 1'b0;
`ifdef FV_QED_SCHED_TIMEOUT_EN
    w_drain_timer_d = '0;
    w_timeout_d     = r_timeout;
`endif

    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StOrig;
        end
      end
      StOrig: begin
        w_orig_count_d = w_orig_next;
        w_commit_cnt_d = w_commit_sum[CNT_W:0];
        if ((w_orig_next != '0) &&
            (switch_req || (w_orig_next == CNT_W'(MAX_ORIG)))) begin
          w_state_d = StDup;
        end
      end
      StDup: begin
        w_dup_count_d  = w_dup_next;
        w_commit_cnt_d = w_commit_sum[CNT_W:0];
        if (w_dup_next == r_orig_count) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_commit_sum > {1'b0, w_target}) begin
          w_overcommit_d = 1'b1;
          w_commit_cnt_d = w_target;
          w_state_d      = StCheck;
        end else begin
          w_commit_cnt_d = w_commit_sum[CNT_W:0];
          if (w_commit_sum[CNT_W:0] == w_target) begin
            w_state_d = StCheck;
          end
`ifdef FV_QED_SCHED_TIMEOUT_EN
          else if (w_timer_next == TmrW'(TIMEOUT)) begin
            w_timeout_d = 1'b1;
            w_clear     = 1'b1;
            w_state_d   = StOrig;
          end else begin
            w_drain_timer_d = w_timer_next;
          end
`endif
        end
      end
      StCheck: begin
        w_clear   = 1'b1;
        w_state_d = StOrig;
      end
      default: begin
        w_clear   = 1'b1;
        w_state_d = StIdle;
      end
    endcase

    // Kill aborts the whole cycle's work, including any overcommit detected in it.
    if (kill && (w_issuing || (r_state == StDrain))) begin
      w_clear        = 1'b1;
      w_state_d      = StOrig;
      w_overcommit_d = r_overcommit;
`ifdef FV_QED_SCHED_TIMEOUT_EN
      w_drain_timer_d = '0;
      w_timeout_d     = r_timeout;
`endif
    end

    if (w_clear) begin
      w_orig_count_d = '0;
      w_dup_count_d  = '0;
      w_commit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      r_state      <= StIdle;
      r_orig_count <= '0;
      r_dup_count  <= '0;
      r_commit_cnt <= '0;
      r_overcommit <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_orig_count <= w_orig_count_d;
      r_dup_count  <= w_dup_count_d;
      r_commit_cnt <= w_commit_cnt_d;
      r_overcommit <= w_overcommit_d;
    end
  end

`ifdef FV_QED_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      r_drain_timer <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_drain_timer <= w_drain_timer_d;
      r_timeout     <= w_timeout_d;
    end
  end

  assign timeout_err = r_timeout;
`endif

  assign issue_is_dup   = (r_state == StDup);
  assign fetch_stall    = ~w_issuing;
  assign qed_ready      = (r_state == StCheck);
  assign orig_count     = r_orig_count;
  assign commit_count   = r_commit_cnt;
  assign overcommit_err = r_overcommit;

endmodule
